// File: rtl/riscv_mul_pkg.sv
// Shared definitions for the sequential RV64M multiplier.
//   XLEN       : operand and result width
//   CNT_W      : iteration counter width (2**CNT_W > XLEN)
//   mulctrl_e  : multiply-group operation encoding (bit2 = valid)
//   state_e    : FSM states of riscv_seq_multiplier
package riscv_mul_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = 7;

   typedef enum logic [2:0] {
      MUL_OP    = 3'b100,
      MULH_OP   = 3'b101,
      MULHSU_OP = 3'b110,
      MULHU_OP  = 3'b111
   } mulctrl_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/riscv_mul_operand_prep.sv
// Combinational operand conditioning for the sequential multiplier.
// Decides which operands are signed, converts them to unsigned magnitudes
// and reports whether the final product has to be negated.
// Ports:
//   mulctrl  in   3     operation encoding (mulctrl_e)
//   rs1data  in   XLEN  multiplicand
//   rs2data  in   XLEN  multiplier
//   rs1_signed / rs2_signed  out  operand is interpreted as signed
//   negate   out  1     exactly one operand is effectively negative
//   rs1_mag / rs2_mag        out  XLEN  unsigned magnitudes
module riscv_mul_operand_prep
   import riscv_mul_pkg::*;
(
   input  logic [2:0]      mulctrl,
   input  logic [XLEN-1:0] rs1data,
   input  logic [XLEN-1:0] rs2data,
   output logic            rs1_signed,
   output logic            rs2_signed,
   output logic            negate,
   output logic [XLEN-1:0] rs1_mag,
   output logic [XLEN-1:0] rs2_mag
);

   logic rs1_neg;
   logic rs2_neg;

   always_comb begin
      rs1_signed = (mulctrl == MUL_OP) || (mulctrl == MULH_OP) || (mulctrl == MULHSU_OP);
      rs2_signed = (mulctrl == MUL_OP) || (mulctrl == MULH_OP);
      rs1_neg    = rs1_signed & rs1data[XLEN-1];
      rs2_neg    = rs2_signed & rs2data[XLEN-1];
      // The most-negative value negates to itself, which read as unsigned is
      // exactly its magnitude 2^(XLEN-1), so no special case is needed.
      rs1_mag    = rs1_neg ? (~rs1data + 1'b1) : rs1data;
      rs2_mag    = rs2_neg ? (~rs2data + 1'b1) : rs2data;
      negate     = rs1_neg ^ rs2_neg;
   end

endmodule

// File: rtl/riscv_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One multiplier bit is consumed per clock in CALC; FIX applies the sign and
// selects the result half.
// Handshake: a request is accepted on an edge where the FSM is in IDLE,
// i_riscv_mul_start=1, i_riscv_mul_mulctrl[2]=1 and i_riscv_mul_flush=0.
// o_riscv_mul_busy is high while the operation is in flight (CALC/FIX);
// o_riscv_mul_done pulses for one cycle with o_riscv_mul_result valid.
// The result stays held until the next completion. Flush aborts silently.
// Ports:
//   i_riscv_mul_clk      in   clock, rising edge
//   i_riscv_mul_rst      in   asynchronous active-high reset
//   i_riscv_mul_start    in   request
//   i_riscv_mul_flush    in   abort in-flight operation
//   i_riscv_mul_mulctrl  in   operation (mulctrl_e)
//   i_riscv_mul_rs1data  in   multiplicand
//   i_riscv_mul_rs2data  in   multiplier
//   o_riscv_mul_busy     out  operation in flight
//   o_riscv_mul_done     out  one-cycle completion pulse
//   o_riscv_mul_result   out  registered result
// Build option: define RISCV_MUL_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier is zero (result unchanged, latency data dependent).
module riscv_seq_multiplier
   import riscv_mul_pkg::*;
(
   input  logic            i_riscv_mul_clk,
   input  logic            i_riscv_mul_rst,
   input  logic            i_riscv_mul_start,
   input  logic            i_riscv_mul_flush,
   input  logic [2:0]      i_riscv_mul_mulctrl,
   input  logic [XLEN-1:0] i_riscv_mul_rs1data,
   input  logic [XLEN-1:0] i_riscv_mul_rs2data,
   output logic            o_riscv_mul_busy,
   output logic            o_riscv_mul_done,
   output logic [XLEN-1:0] o_riscv_mul_result
);

   state_e              state_q, state_d;
   logic                load, step, finish;

   logic                rs1_signed, rs2_signed, negate;
   logic [XLEN-1:0]     rs1_mag, rs2_mag;
   logic                unused_sign_flags;

   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     mcand_q;
   logic [XLEN-1:0]     mplier_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                neg_q;
   logic [2:0]          ctrl_q;
   logic [XLEN-1:0]     result_q;
   logic                done_q;

   logic [XLEN:0]       sum;
   logic [2*XLEN-1:0]   acc_next;
   logic [2*XLEN-1:0]   prod_aligned;
   logic [2*XLEN-1:0]   prod_final;
   logic [XLEN-1:0]     result_d;

   riscv_mul_operand_prep u_prep (
      .mulctrl    (i_riscv_mul_mulctrl),
      .rs1data    (i_riscv_mul_rs1data),
      .rs2data    (i_riscv_mul_rs2data),
      .rs1_signed (rs1_signed),
      .rs2_signed (rs2_signed),
      .negate     (negate),
      .rs1_mag    (rs1_mag),
      .rs2_mag    (rs2_mag)
   );

   // Signedness is already folded into the magnitudes and the negate flag.
   assign unused_sign_flags = rs1_signed | rs2_signed;

   // ---------------- FSM ----------------
   always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
      if (i_riscv_mul_rst) state_q <= IDLE;
      else                 state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_riscv_mul_start && i_riscv_mul_mulctrl[2] && !i_riscv_mul_flush) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (i_riscv_mul_flush) begin
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == CNT_W'(XLEN - 1))
                  state_d = FIX;
`ifdef RISCV_MUL_EARLY_TERM_EN
               // This iteration consumes the last set multiplier bit.
               else if (mplier_q[XLEN-1:1] == '0)
                  state_d = FIX;
`endif
            end
         end
         FIX: begin
            state_d = IDLE;
            finish  = !i_riscv_mul_flush;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_comb begin
      // Carry out of the upper-half add becomes the new MSB after the shift.
      sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
      acc_next = {sum, acc_q[XLEN-1:1]};
   end

`ifdef RISCV_MUL_EARLY_TERM_EN
   // cnt_q holds the iterations done; the skipped ones would only have
   // shifted the accumulator right, so apply those shifts in one go.
   logic [CNT_W-1:0] shift_amt;
   assign shift_amt    = CNT_W'(XLEN) - cnt_q;
   assign prod_aligned = acc_q >> shift_amt;
`else
   assign prod_aligned = acc_q;
`endif

   always_comb begin
      prod_final = neg_q ? (~prod_aligned + 1'b1) : prod_aligned;
      result_d   = (ctrl_q == MUL_OP) ? prod_final[XLEN-1:0] : prod_final[2*XLEN-1:XLEN];
   end

   always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
      if (i_riscv_mul_rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ctrl_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= finish;
         if (load) begin
            acc_q    <= '0;
            mcand_q  <= rs1_mag;
            mplier_q <= rs2_mag;
            cnt_q    <= '0;
            neg_q    <= negate;
            ctrl_q   <= i_riscv_mul_mulctrl;
         end else if (step) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
         if (finish) result_q <= result_d;
      end
   end

   assign o_riscv_mul_busy   = (state_q != IDLE);
   assign o_riscv_mul_done   = done_q;
   assign o_riscv_mul_result = result_q;

endmodule

// File: tb/tb_riscv_seq_multiplier.sv
// Directed testbench for riscv_seq_multiplier. Edges are numbered from the
// edge that samples start (edge 1). Honors RISCV_MUL_EARLY_TERM_EN.
module tb_riscv_seq_multiplier;
   import riscv_mul_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  ctrl;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int n_vec  = 0;
   int n_miss = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[14];

   riscv_seq_multiplier dut (
      .i_riscv_mul_clk     (clk),
      .i_riscv_mul_rst     (rst),
      .i_riscv_mul_start   (start),
      .i_riscv_mul_flush   (flush),
      .i_riscv_mul_mulctrl (ctrl),
      .i_riscv_mul_rs1data (rs1),
      .i_riscv_mul_rs2data (rs2),
      .o_riscv_mul_busy    (busy),
      .o_riscv_mul_done    (done),
      .o_riscv_mul_result  (result)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Expected edge on which done is first seen (edge 1 samples start).
   function automatic int exp_lat(input logic [2:0] op, input logic [63:0] b);
`ifdef RISCV_MUL_EARLY_TERM_EN
      logic [63:0] m;
      int n;
      m = (((op == MUL_OP) || (op == MULH_OP)) && b[63]) ? (~b + 64'd1) : b;
      n = 1;
      for (int i = 0; i < 64; i++) if (m[i]) n = i + 1;
      return n + 2;
`else
      return 66;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, then track busy, done latency, result and pulse width.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e);
      int  edge_n;
      bit  seen;
      bit  busy_ok;
      logic [63:0] exp_v;
      exp_q.push_back(e);
      start = 1'b1; ctrl = op; rs1 = a; rs2 = b;
      tick();
      start = 1'b0;
      edge_n = 1; seen = 1'b0; busy_ok = 1'b1;
      while (edge_n < 200 && !seen) begin
         if (done) seen = 1'b1;
         else begin
            if (!busy) busy_ok = 1'b0;
            tick();
            edge_n++;
         end
      end
      exp_v = exp_q.pop_front();
      check({nm, " latency"}, 64'(edge_n), 64'(exp_lat(op, b)));
      check({nm, " result"}, result, exp_v);
      check({nm, " busy while running"}, 64'(busy_ok), 64'd1);
      tick();
      check({nm, " done width"}, 64'(done), 64'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      int dones;
      int first_done;
      int flush_edge;
      logic [63:0] last_exp;

      vecs[0]  = '{MUL_OP,    64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1]  = '{MULH_OP,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
      vecs[2]  = '{MULHU_OP,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[3]  = '{MULHSU_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4]  = '{MUL_OP,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
      vecs[5]  = '{MULH_OP,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[6]  = '{MUL_OP,    64'd5,                   64'd6,                   64'd30};
      vecs[7]  = '{MULHU_OP,  64'd2,                   64'd3,                   64'd0};
      vecs[8]  = '{MUL_OP,    64'h1234,                64'd0,                   64'd0};
      vecs[9]  = '{MUL_OP,    64'd3,                   64'd4,                   64'd12};
      vecs[10] = '{MULHSU_OP, 64'h8000_0000_0000_0000, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[11] = '{MULH_OP,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[12] = '{MUL_OP,    64'h1_0000_0001,         64'h1_0000_0001,         64'h0000_0002_0000_0001};
      vecs[13] = '{MULHU_OP,  64'h8000_0000_0000_0000, 64'd2,                   64'd1};

      rst = 1'b1; start = 1'b0; flush = 1'b0; ctrl = 3'b000; rs1 = '0; rs2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b0;
      tick();

      // Table of directed vectors.
      for (int i = 0; i < 14; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      end
      last_exp = vecs[13].exp;

      // Start with mulctrl[2]=0 must be ignored.
      start = 1'b1; ctrl = 3'b011; rs1 = 64'd9; rs2 = 64'd9;
      tick();
      start = 1'b0;
      check("nop start busy", 64'(busy), 64'd0);
      check("nop start result held", result, last_exp);

      // Flush in CALC: no done, result held.
`ifdef RISCV_MUL_EARLY_TERM_EN
      flush_edge = 3;
`else
      flush_edge = 10;
`endif
      start = 1'b1; ctrl = MUL_OP; rs1 = 64'd5; rs2 = 64'd6;
      tick();
      start = 1'b0;
      for (int e = 2; e < flush_edge; e++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy drop", 64'(busy), 64'd0);
      dones = 0;
      for (int e = 0; e < 80; e++) begin
         if (done) dones++;
         tick();
      end
      check("flush no done", 64'(dones), 64'd0);
      check("flush result held", result, last_exp);

      // Flush together with start in IDLE: flush wins.
      start = 1'b1; flush = 1'b1; ctrl = MUL_OP; rs1 = 64'd5; rs2 = 64'd6;
      tick();
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", 64'(busy), 64'd0);

      // Rerun 5*6 with a start issued while busy; exactly one done expected.
      start = 1'b1; ctrl = MUL_OP; rs1 = 64'd5; rs2 = 64'd6;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; ctrl = MULHU_OP; rs1 = '1; rs2 = '1;
      tick();
      start = 1'b0;
      dones = 0; first_done = 0;
      for (int e = 4; e < 120; e++) begin
         if (done) begin
            dones++;
            if (first_done == 0) first_done = e - 1;
         end
         tick();
      end
      check("busy start done count", 64'(dones), 64'd1);
      check("busy start latency", 64'(first_done), 64'(exp_lat(MUL_OP, 64'd6)));
      check("busy start result", result, 64'd30);

      // Asynchronous reset mid-operation.
      start = 1'b1; ctrl = MULHU_OP; rs1 = '1; rs2 = '1;
      tick();
      start = 1'b0;
      for (int e = 2; e <= 20; e++) tick();
      #2 rst = 1'b1;
      #1;
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst done", 64'(done), 64'd0);
      check("async rst result", result, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post rst idle", 64'(busy), 64'd0);
      run_op("post rst MULHU 2*3", MULHU_OP, 64'd2, 64'd3, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
